instr_imm_encoder: RTL and testbench
====================================

INSTR_IMM_ENCODER -- requirements
Module: instr_imm_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 bit each: upstream handshake; a transfer occurs when both are high at a clk edge.
REQ-004 SHALL have fmt, input, 3 bits: instruction format; 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 reserved.
REQ-005 SHALL have opcode (7), funct3 (3), funct7 (7), rd/rs1/rs2 (5 each), all inputs: instruction fields.
REQ-006 SHALL have imm, input, 32 bits: immediate value to pack.
REQ-007 SHALL have out_valid/out_ready, output/input, 1 bit each: downstream handshake.
REQ-008 SHALL have out_instr (output, 32 bits): encoded word; out_err (output, 1 bit): range/format error for that word.
REQ-009 SHALL have cnt_enc and cnt_err, outputs, 16 bits each: words delivered, and errored words delivered.

Function
REQ-010 SHALL pack fields as: R funct7|rs2|rs1|funct3|rd|opcode; I imm[11:0]|rs1|funct3|rd|opcode; S imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-011 SHALL pack B as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; U as imm[31:12]|rd|opcode; J as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-012 SHALL pack CSR as {funct7,rs2} (CSR address)|imm[4:0] (zimm, in rs1 field)|funct3|rd|opcode.
REQ-013 SHALL flag out_err when imm is not exactly recoverable by the team's zero-extending immediate decoders: I/S imm[31:12]!=0; B imm[31:13]!=0 or imm[0]=1; J imm[31:21]!=0 or imm[0]=1; U imm[11:0]!=0; CSR imm[31:5]!=0.
REQ-014 SHALL flag out_err for fmt=7, with out_instr=32'h0; R never errors, and imm is ignored for R.
REQ-015 SHALL still emit the truncated packed word on range error (never dropped).
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers the inputs and the range-check result; stage 2 registers the packed out_instr/out_err.
REQ-017 SHALL present a word on out_valid exactly 2 cycles after its input transfer when out_ready is held high; throughput is 1 word/cycle.
REQ-018 SHALL hold out_instr/out_err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute in_ready = !s1_valid || s1 advances; s1 advances when !s2_valid || out_ready. in_ready is combinational, with no path from in_valid.
REQ-020 SHALL never drop or duplicate words under any valid/ready pattern, including simultaneous accept and deliver with both stages full.
REQ-021 SHALL increment cnt_enc on each out_valid&&out_ready, and cnt_err on each such transfer with out_err=1; both saturate at 16'hFFFF.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear both stage valids, out_instr, out_err, cnt_enc and cnt_err to 0; in_ready is then 1.
REQ-023 SHALL discard in-flight words when reset asserts mid-operation; none appear after release.
REQ-024 SHALL accept a new input on the first clk edge after rst_n deasserts.

Structure
REQ-025 SHALL take the format enum (R, I, S, B, U, J, CSR, RSVD) and the opcode constants from a shared package, instr_enc_pkg, which the decoder-side bench also uses.
REQ-026 SHALL place packing and range check in one combinational sub-module, instr_field_pack (fmt/fields/imm in, word/err out); the pipeline, handshake and counters stay in instr_imm_encoder.

Verification
REQ-027 SHALL cover: I fmt, opcode=7'h13, rd=1, rs1=2, funct3=0, imm=32'h7FF, out_ready=1 -> out_instr=32'h7FF10093, out_err=0, 2 cycles after transfer.
REQ-028 SHALL cover: B fmt, imm=32'h1001 -> out_err=1, word still delivered, cnt_err=1; B fmt with imm=32'h1000 -> out_err=0, and the word round-trips through the B decoder to 32'h1000.
REQ-029 SHALL cover: 8 back-to-back inputs with out_ready low for cycles 3-6 -> in_ready low once both stages are full; all 8 words are delivered in order and out_instr is stable during the stall.
REQ-030 SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 immediately; no stale words after release; counters at 0.
REQ-031 SHALL cover: fmt=7 -> out_instr=0 and out_err=1; counter preloaded by 65540 transfers -> cnt_enc=16'hFFFF.
REQ-032 SHALL cover: random U/J/S/CSR immediates -> every legal word round-trips through the team's immediate decoders to the original imm.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared formats, opcodes and field bundle for the instruction encoder.
// The decoder-side bench imports the same package.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    // True when the zero-extending decoders cannot rebuild imm exactly.
    function automatic logic imm_range_err(input fmt_e f, input logic [31:0] imm);
        logic e;
        e = 1'b0;
        unique case (f)
            FMT_R:          e = 1'b0;
            FMT_I, FMT_S:   e = |imm[31:12];
            FMT_B:          e = (|imm[31:13]) || imm[0];
            FMT_U:          e = |imm[11:0];
            FMT_J:          e = (|imm[31:21]) || imm[0];
            FMT_CSR:        e = |imm[31:5];
            FMT_RSVD:       e = 1'b1;
            default:        e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer with immediate range check.
// Out-of-range immediates are still packed, truncated to the field.
module instr_field_pack
    import instr_enc_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        err
);

    always_comb begin
        word = '0;
        err  = imm_range_err(f.fmt, f.imm);
        unique case (f.fmt)
            FMT_R:
                word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I:
                word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S:
                word = {f.imm[11:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:0], f.opcode};
            FMT_B:
                word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], f.opcode};
            FMT_U:
                word = {f.imm[31:12], f.rd, f.opcode};
            FMT_J:
                word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                        f.rd, f.opcode};
            FMT_CSR:
                word = {f.funct7, f.rs2, f.imm[4:0], f.funct3, f.rd, f.opcode};
            FMT_RSVD:
                word = '0;
            default:
                word = '0;
        endcase
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// Two-stage instruction encoder: stage 1 holds fields and range check,
// stage 2 holds the packed word; valid/ready on both sides.
module instr_imm_encoder
    import instr_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] cnt_enc,
    output logic [15:0] cnt_err
);

    fields_t     in_f;
    fields_t     s1_f;
    logic        s1_valid;
    logic        s1_err;
    logic        s2_valid;
    logic        s1_adv;
    logic        fire_out;
    logic [31:0] pk_word;
    logic        pk_err;

    assign in_f = '{
        fmt:    fmt_e'(fmt),
        opcode: opcode,
        funct3: funct3,
        funct7: funct7,
        rd:     rd,
        rs1:    rs1,
        rs2:    rs2,
        imm:    imm
    };

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    assign fire_out  = s2_valid && out_ready;

    instr_field_pack u_pack (
        .f    (s1_f),
        .word (pk_word),
        .err  (pk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_err   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_f   <= in_f;
                s1_err <= imm_range_err(in_f.fmt, in_f.imm);
            end
        end
    end

    // The packer re-derives the same error; OR keeps both views consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= pk_word;
                out_err   <= s1_err | pk_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_enc <= '0;
            cnt_err <= '0;
        end else if (fire_out) begin
            if (cnt_enc != 16'hFFFF)
                cnt_enc <= cnt_enc + 16'd1;
            if (out_err && cnt_err != 16'hFFFF)
                cnt_err <= cnt_err + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed bench for instr_imm_encoder: packing, range errors,
// handshake stalls, reset in flight, counter saturation.
module tb_instr_imm_encoder;
    import instr_enc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] cnt_enc;
    logic [15:0] cnt_err;

    int compared = 0;
    int mismatched = 0;
    logic [32:0] cap[$];

    instr_imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_enc   (cnt_enc),
        .cnt_err   (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delivered words {err, instr}, taken mid-cycle before the transfer edge.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            cap.push_back({out_err, out_instr});

    function automatic logic [31:0] dec_b(input logic [31:0] w);
        return {19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] dec_u(input logic [31:0] w);
        return {w[31:12], 12'd0};
    endfunction
    function automatic logic [31:0] dec_j(input logic [31:0] w);
        return {11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction
    function automatic logic [31:0] dec_s(input logic [31:0] w);
        return {20'd0, w[31:25], w[11:7]};
    endfunction
    function automatic logic [31:0] dec_csr(input logic [31:0] w);
        return {27'd0, w[19:15]};
    endfunction

    task automatic reset_dut;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cap.delete();
    endtask

    task automatic push(input logic [2:0] f_, input logic [6:0] op_,
                        input logic [2:0] f3_, input logic [6:0] f7_,
                        input logic [4:0] rd_, input logic [4:0] s1_,
                        input logic [4:0] s2_, input logic [31:0] im_);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        fmt = f_; opcode = op_; funct3 = f3_; funct7 = f7_;
        rd = rd_; rs1 = s1_; rs2 = s2_; imm = im_;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1 n++;
        end while (!ok && n < 100);
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_cap(input int want);
        int n;
        n = 0;
        while (cap.size() < want && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        if (cap.size() < want) begin
            compared++; mismatched++;
            $display("FAIL cap_timeout: got %0d words want %0d", cap.size(), want);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        fmt = 0; opcode = 0; funct3 = 0; funct7 = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        #2;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        compared++;
        if (out_instr !== 32'h0 || out_err !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_out: got %h/%b want 0/0", out_instr, out_err);
        end
        compared++;
        if (cnt_enc !== 16'h0 || cnt_err !== 16'h0) begin
            mismatched++;
            $display("FAIL rst_cnt: got %h/%h want 0/0", cnt_enc, cnt_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_i_fmt;
        reset_dut();
        push(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h7FF);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL i_early_valid: got %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b1 || out_instr !== 32'h7FF10093 || out_err !== 1'b0) begin
            mismatched++;
            $display("FAIL i_word: got v=%b %h e=%b want v=1 7ff10093 e=0",
                     out_valid, out_instr, out_err);
        end
    endtask

    task automatic test_b_fmt;
        reset_dut();
        push(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h1001);
        wait_cap(1);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (cap.size() < 1 || cap[0] !== {1'b1, 32'h80208063}) begin
            mismatched++;
            $display("FAIL b_err_word: got %h want 1_80208063",
                     cap.size() > 0 ? cap[0] : 33'h0);
        end
        compared++;
        if (cnt_err !== 16'd1 || cnt_enc !== 16'd1) begin
            mismatched++;
            $display("FAIL b_err_cnt: got enc=%0d err=%0d want 1/1", cnt_enc, cnt_err);
        end
        push(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h1000);
        wait_cap(2);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (cap.size() < 2 || cap[1] !== {1'b0, 32'h80208063}) begin
            mismatched++;
            $display("FAIL b_ok_word: got %h want 0_80208063",
                     cap.size() > 1 ? cap[1] : 33'h0);
        end
        compared++;
        if (cap.size() < 2 || dec_b(cap[1][31:0]) !== 32'h1000) begin
            mismatched++;
            $display("FAIL b_roundtrip: got %h want 00001000",
                     cap.size() > 1 ? dec_b(cap[1][31:0]) : 32'h0);
        end
        compared++;
        if (cnt_err !== 16'd1 || cnt_enc !== 16'd2) begin
            mismatched++;
            $display("FAIL b_ok_cnt: got enc=%0d err=%0d want 2/1", cnt_enc, cnt_err);
        end
    endtask

    task automatic test_range_err;
        logic [2:0]  vf[11] = '{FMT_I, FMT_I, FMT_U, FMT_CSR, FMT_J, FMT_J,
                               FMT_S, FMT_R, FMT_RSVD, FMT_U, FMT_CSR};
        logic [6:0]  vo[11] = '{7'h13, 7'h13, 7'h37, 7'h73, 7'h6F, 7'h6F,
                               7'h23, 7'h33, 7'h33, 7'h37, 7'h73};
        logic [2:0]  v3[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        logic [6:0]  v7[11] = '{0, 0, 0, 0, 0, 0, 0, 7'h20, 7'h20, 0, 0};
        logic [4:0]  vd[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        logic [4:0]  va[11] = '{0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0};
        logic [4:0]  vb[11] = '{0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0};
        logic [31:0] vi[11] = '{32'h1000, 32'hFFF, 32'h123, 32'h20,
                               32'h200000, 32'h100000, 32'h1000,
                               32'hFFFFFFFF, 32'h0, 32'hFFFFF000, 32'h1F};
        logic [32:0] vx[11] = '{{1'b1, 32'h00000013}, {1'b0, 32'hFFF00013},
                               {1'b1, 32'h00000037}, {1'b1, 32'h00001073},
                               {1'b1, 32'h0000006F}, {1'b0, 32'h8000006F},
                               {1'b1, 32'h00000023}, {1'b0, 32'h403100B3},
                               {1'b1, 32'h00000000}, {1'b0, 32'hFFFFF037},
                               {1'b0, 32'h000F9073}};
        reset_dut();
        for (int i = 0; i < 11; i++)
            push(vf[i], vo[i], v3[i], v7[i], vd[i], va[i], vb[i], vi[i]);
        wait_cap(11);
        for (int i = 0; i < 11; i++) begin
            compared++;
            if (cap.size() <= i || cap[i] !== vx[i]) begin
                mismatched++;
                $display("FAIL range_vec%0d: got %h want %h", i,
                         cap.size() > i ? cap[i] : 33'h0, vx[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] held;
        logic [31:0] exp_w;
        reset_dut();
        held = '0;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    push(FMT_R, OP_REG, 3'd0, 7'd0, 5'(i), 5'(i), 5'(i), 32'h0);
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(negedge clk);
                    if (c == 3)
                        held = out_instr;
                    if (c == 4) begin
                        compared++;
                        if (in_ready !== 1'b0) begin
                            mismatched++;
                            $display("FAIL b2b_in_ready: got %b want 0", in_ready);
                        end
                    end
                    if (c >= 4 && c <= 6) begin
                        compared++;
                        if (out_valid !== 1'b1 || out_instr !== held) begin
                            mismatched++;
                            $display("FAIL b2b_stall_c%0d: got v=%b %h want v=1 %h",
                                     c, out_valid, out_instr, held);
                        end
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_cap(8);
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (cap.size() != 8) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d words want 8", cap.size());
        end
        for (int i = 1; i <= 8; i++) begin
            exp_w = {7'd0, 5'(i), 5'(i), 3'd0, 5'(i), OP_REG};
            compared++;
            if (cap.size() < i || cap[i-1] !== {1'b0, exp_w}) begin
                mismatched++;
                $display("FAIL b2b_word%0d: got %h want 0_%h", i,
                         cap.size() >= i ? cap[i-1] : 33'h0, exp_w);
            end
        end
    endtask

    task automatic test_reset_midflight;
        reset_dut();
        out_ready = 1'b0;
        push(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd7, 5'd7, 5'd0, 32'h11);
        push(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd8, 5'd8, 5'd0, 32'h22);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_rst_async: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        compared++;
        if (cnt_enc !== 16'h0 || cnt_err !== 16'h0 || out_instr !== 32'h0) begin
            mismatched++;
            $display("FAIL mid_rst_clear: got %h/%h/%h want 0", cnt_enc, cnt_err, out_instr);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        push(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'h5);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_early_valid: got %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00520193) begin
            mismatched++;
            $display("FAIL mid_first_word: got v=%b %h want v=1 00520193",
                     out_valid, out_instr);
        end
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (cap.size() != 1 || cnt_enc !== 16'd1) begin
            mismatched++;
            $display("FAIL mid_stale: got %0d words cnt=%0d want 1/1", cap.size(), cnt_enc);
        end
    endtask

    task automatic test_saturation;
        reset_dut();
        fmt = FMT_RSVD; opcode = OP_REG; funct3 = 0; funct7 = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (cnt_enc !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL sat_enc: got %h want ffff", cnt_enc);
        end
        compared++;
        if (cnt_err !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL sat_err: got %h want ffff", cnt_err);
        end
        compared++;
        if (cap.size() != 65540) begin
            mismatched++;
            $display("FAIL sat_words: got %0d want 65540", cap.size());
        end
        cap.delete();
    endtask

    task automatic test_roundtrip;
        logic [31:0] exp_imm[24];
        int          kind[24];
        logic [31:0] r;
        logic [31:0] got;
        reset_dut();
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            kind[i] = i % 4;
            case (kind[i])
                0: begin
                    exp_imm[i] = r & 32'hFFFFF000;
                    push(FMT_U, OP_LUI, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, exp_imm[i]);
                end
                1: begin
                    exp_imm[i] = r & 32'h001FFFFE;
                    push(FMT_J, OP_JAL, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, exp_imm[i]);
                end
                2: begin
                    exp_imm[i] = r & 32'h00000FFF;
                    push(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'(i), 5'(i + 1), exp_imm[i]);
                end
                default: begin
                    exp_imm[i] = r & 32'h0000001F;
                    push(FMT_CSR, OP_SYSTEM, 3'd5, 7'h18, 5'(i), 5'd0, 5'd1, exp_imm[i]);
                end
            endcase
        end
        wait_cap(24);
        for (int i = 0; i < 24; i++) begin
            got = 32'h0;
            if (cap.size() > i)
                case (kind[i])
                    0:       got = dec_u(cap[i][31:0]);
                    1:       got = dec_j(cap[i][31:0]);
                    2:       got = dec_s(cap[i][31:0]);
                    default: got = dec_csr(cap[i][31:0]);
                endcase
            compared++;
            if (cap.size() <= i || cap[i][32] !== 1'b0 || got !== exp_imm[i]) begin
                mismatched++;
                $display("FAIL rt_word%0d kind%0d: got imm %h err %b want %h err 0",
                         i, kind[i], got, cap.size() > i ? cap[i][32] : 1'bx,
                         exp_imm[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_fmt();
        test_b_fmt();
        test_range_err();
        test_back_to_back();
        test_reset_midflight();
        test_roundtrip();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
